// File: rtl/comb_arb_pkg.sv
// Shared types and defaults for the combination-unit request arbiter.
// Provides the arbiter FSM state type, default operand/answer widths and
// the answer value reported with an error response.
package comb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_N,
    SEND_M,
    WAIT,
    RESP
  } arb_state_t;

  localparam int unsigned DEF_NW     = 4;
  localparam int unsigned DEF_AW     = 15;
  localparam int unsigned ERR_ANSWER = 0;

endpackage

// File: rtl/comb_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
// Searches req upward from ptr, wrapping from NREQ-1 to 0, and returns the
// first set bit as a one-hot vector plus its index.
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  IW    search start position (highest priority)
//   onehot out NREQ  one-hot winner, all zero when req == 0
//   idx    out IW    winner index, 0 when req == 0
//   found  out 1     any request present
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            found
);

  logic [31:0]   pos;
  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      cand = IW'(pos);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/comb_req_arbiter.sv
// comb_req_arbiter: shares one combination unit between NREQ requesters.
// A round-robin winner has its N then M operand serialised onto the unit
// bus with u_start high for two cycles; the unit answer (captured on the
// first Done seen while waiting) is returned to the winner as a one-cycle
// rsp_valid pulse. M > N is rejected without starting the unit.
// Optional feature: define COMB_ARB_TIMEOUT_EN to bound the wait for Done
// to TIMEOUT_CYC cycles, after which an error response is issued.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req/req_n/req_m     per-requester request level and packed operands
//   gnt                 registered one-hot grant, held through the response
//   rsp_valid           one-hot one-cycle response pulse
//   rsp_answer, rsp_err result and error flag, qualified by rsp_valid
//   u_start, u_n        unit start and serial operand bus
//   u_done, u_answer    unit Done level and answer
module comb_req_arbiter
  import comb_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned NW          = DEF_NW,
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*NW-1:0]   req_n,
  input  logic [NREQ*NW-1:0]   req_m,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [AW-1:0]        rsp_answer,
  output logic                 rsp_err,
  output logic                 u_start,
  output logic [NW-1:0]        u_n,
  input  logic                 u_done,
  input  logic [AW-1:0]        u_answer
);

  localparam int unsigned   IW       = $clog2(NREQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [AW-1:0]   rsp_answer_q, rsp_answer_d;
  logic            rsp_err_q, rsp_err_d;
  logic            u_start_q, u_start_d;
  logic [NW-1:0]   u_n_q, u_n_d;
  logic [NW-1:0]   m_q, m_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic [NW-1:0]   sel_n, sel_m;

`ifdef COMB_ARB_TIMEOUT_EN
  localparam int unsigned   TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign sel_n = req_n[pick_idx*NW +: NW];
  assign sel_m = req_m[pick_idx*NW +: NW];

  // u_start/u_n are registered: they are loaded on the edge that enters
  // SEND_N/SEND_M so they line up with the state, and clear on reset.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rsp_valid_d  = '0;
    rsp_answer_d = rsp_answer_q;
    rsp_err_d    = rsp_err_q;
    u_start_d    = u_start_q;
    u_n_d        = u_n_q;
    m_d          = m_q;
    win_d        = win_q;
    ptr_d        = ptr_q;
`ifdef COMB_ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d = pick_onehot;
          win_d = pick_idx;
          m_d   = sel_m;
          if (sel_m > sel_n) begin
            rsp_valid_d  = pick_onehot;
            rsp_err_d    = 1'b1;
            rsp_answer_d = AW'(ERR_ANSWER);
            state_d      = RESP;
          end else begin
            u_start_d = 1'b1;
            u_n_d     = sel_n;
            state_d   = SEND_N;
          end
        end
      end
      SEND_N: begin
        u_n_d   = m_q;
        state_d = SEND_M;
      end
      SEND_M: begin
        u_start_d = 1'b0;
        u_n_d     = '0;
        state_d   = WAIT;
`ifdef COMB_ARB_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
      end
      WAIT: begin
        if (u_done) begin
          rsp_valid_d  = gnt_q;
          rsp_answer_d = u_answer;
          rsp_err_d    = 1'b0;
          state_d      = RESP;
        end
`ifdef COMB_ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          rsp_valid_d  = gnt_q;
          rsp_answer_d = AW'(ERR_ANSWER);
          rsp_err_d    = 1'b1;
          state_d      = RESP;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
`endif
      end
      RESP: begin
        gnt_d        = '0;
        rsp_answer_d = '0;
        rsp_err_d    = 1'b0;
        ptr_d        = (win_q == LAST_IDX) ? '0 : win_q + IW'(1);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_answer_q <= '0;
      rsp_err_q    <= 1'b0;
      u_start_q    <= 1'b0;
      u_n_q        <= '0;
      m_q          <= '0;
      win_q        <= '0;
      ptr_q        <= '0;
`ifdef COMB_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_answer_q <= rsp_answer_d;
      rsp_err_q    <= rsp_err_d;
      u_start_q    <= u_start_d;
      u_n_q        <= u_n_d;
      m_q          <= m_d;
      win_q        <= win_d;
      ptr_q        <= ptr_d;
`ifdef COMB_ARB_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_answer = rsp_answer_q;
  assign rsp_err    = rsp_err_q;
  assign u_start    = u_start_q;
  assign u_n        = u_n_q;

endmodule

// File: tb/tb_comb_req_arbiter.sv
// Self-checking bench for comb_req_arbiter: a behavioural combination unit
// (C(N,M), fixed latency) plus a round-robin reference model of who must be
// served next and with what result.
module tb_comb_req_arbiter;

  localparam int NREQ     = 4;
  localparam int NW       = 4;
  localparam int AW       = 15;
  localparam int UNIT_LAT = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*NW-1:0]   req_n = '0;
  logic [NREQ*NW-1:0]   req_m = '0;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rsp_valid;
  logic [AW-1:0]        rsp_answer;
  logic                 rsp_err;
  logic                 u_start;
  logic [NW-1:0]        u_n;
  logic                 u_done = 1'b0;
  logic [AW-1:0]        u_answer = '0;

  always #5 clk = ~clk;

  comb_req_arbiter #(
    .NREQ        (NREQ),
    .NW          (NW),
    .AW          (AW),
    .TIMEOUT_CYC (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_n      (req_n),
    .req_m      (req_m),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_answer (rsp_answer),
    .rsp_err    (rsp_err),
    .u_start    (u_start),
    .u_n        (u_n),
    .u_done     (u_done),
    .u_answer   (u_answer)
  );

  int checks = 0;
  int errors = 0;

  int              op_n [NREQ];
  int              op_m [NREQ];
  bit              keep [NREQ];
  logic [NREQ-1:0] pending = '0;
  int              mptr = 0;
  int              served_q[$];
  int              ans_q[$];
  int              err_q[$];
  int              first_lat;
  int              st_cnt, st_n, st_m;
  bit              unit_dead = 1'b0;
  bit              late_done = 1'b0;

  function automatic int binom(input int n, input int m);
    int r = 1;
    if (m > n) return 0;
    for (int i = 0; i < m; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic int rr_model(input logic [NREQ-1:0] mask, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Behavioural unit: N on the first start cycle, M on the second, Done with
  // C(N,M) UNIT_LAT cycles after M, held for two cycles.
  int um_ph = 0, um_n = 0, um_m = 0, um_cnt = 0, um_hold = 0;
  always @(posedge clk) begin
    if (rst) begin
      um_ph <= 0;
      u_done <= 1'b0;
    end else if (late_done) begin
      u_done <= 1'b1;
    end else begin
      case (um_ph)
        0: begin
          u_done <= 1'b0;
          if (u_start) begin um_n <= int'(u_n); um_ph <= 1; end
        end
        1: begin um_m <= int'(u_n); um_cnt <= 0; um_ph <= 2; end
        2: begin
          if (!unit_dead) begin
            if (um_cnt + 1 == UNIT_LAT) begin
              u_done   <= 1'b1;
              u_answer <= AW'(binom(um_n, um_m));
              um_hold  <= 2;
              um_ph    <= 3;
            end
            um_cnt <= um_cnt + 1;
          end
        end
        default: begin
          if (um_hold == 1) begin u_done <= 1'b0; um_ph <= 0; end
          um_hold <= um_hold - 1;
        end
      endcase
    end
  end

  task automatic set_op(input int i, input int n, input int m);
    op_n[i] = n;
    op_m[i] = m;
    req_n[i*NW +: NW] = NW'(n);
    req_m[i*NW +: NW] = NW'(m);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    st_cnt = 0;
  endtask

  task automatic serve(input int nserv, input int budget);
    int guard = 0;
    int served = 0;
    int w, act, exp_ans;
    bit bad;
    logic [NREQ-1:0] exp_oh;
    served_q.delete(); ans_q.delete(); err_q.delete();
    st_cnt = 0;
    while (served < nserv && guard < budget) begin
      @(negedge clk);
      guard++;
      if (u_start) begin
        if (st_cnt == 0) st_n = int'(u_n);
        else if (st_cnt == 1) st_m = int'(u_n);
        st_cnt++;
      end
      checks++;
      if (!$onehot0(gnt)) begin
        errors++; $display("FAIL gnt_onehot got %b expected one-hot or zero", gnt);
      end
      if (rsp_valid != '0) begin
        w = rr_model(pending, mptr);
        exp_oh = '0;
        exp_oh[w] = 1'b1;
        bad = op_m[w] > op_n[w];
        exp_ans = bad ? 0 : binom(op_n[w], op_m[w]);
        if (served == 0) first_lat = guard;
        act = -1;
        for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) act = i;
        served_q.push_back(act);
        ans_q.push_back(int'(rsp_answer));
        err_q.push_back(int'(rsp_err));
        checks++;
        if (rsp_valid !== exp_oh) begin
          errors++; $display("FAIL rsp_valid got %b expected %b", rsp_valid, exp_oh);
        end
        checks++;
        if (gnt !== exp_oh) begin
          errors++; $display("FAIL gnt_in_resp got %b expected %b", gnt, exp_oh);
        end
        checks++;
        if (int'(rsp_answer) != exp_ans) begin
          errors++; $display("FAIL rsp_answer got %0d expected %0d", rsp_answer, exp_ans);
        end
        checks++;
        if (rsp_err !== bad) begin
          errors++; $display("FAIL rsp_err got %b expected %b", rsp_err, bad);
        end
        checks++;
        if (st_cnt != (bad ? 0 : 2)) begin
          errors++; $display("FAIL start_cycles got %0d expected %0d", st_cnt, bad ? 0 : 2);
        end
        if (!bad) begin
          checks++;
          if (st_n != op_n[w] || st_m != op_m[w]) begin
            errors++;
            $display("FAIL u_n_seq got %0d,%0d expected %0d,%0d", st_n, st_m, op_n[w], op_m[w]);
          end
        end
        served++;
        if (!keep[w]) begin pending[w] = 1'b0; req[w] = 1'b0; end
        if (served == nserv) begin
          for (int i = 0; i < NREQ; i++) begin
            if (keep[i]) begin pending[i] = 1'b0; req[i] = 1'b0; keep[i] = 1'b0; end
          end
        end
        mptr = (w + 1) % NREQ;
        st_cnt = 0;
      end
    end
    checks++;
    if (served != nserv) begin
      errors++; $display("FAIL serve_timeout got %0d responses expected %0d", served, nserv);
    end
  endtask

  task automatic issue(input logic [NREQ-1:0] mask);
    @(negedge clk);
    pending = mask;
    req = mask;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (gnt !== '0 || rsp_valid !== '0) begin
      errors++; $display("FAIL reset_gnt_valid got %b/%b expected 0/0", gnt, rsp_valid);
    end
    checks++;
    if (rsp_answer !== '0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp got %0d/%b expected 0/0", rsp_answer, rsp_err);
    end
    checks++;
    if (u_start !== 1'b0 || u_n !== '0) begin
      errors++; $display("FAIL reset_unit got %b/%0d expected 0/0", u_start, u_n);
    end
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic test_single();
    set_op(0, 5, 3);
    issue(4'b0001);
    serve(1, 200);
    checks++;
    if (served_q.size() != 1 || served_q[0] != 0 || ans_q[0] != 10 || err_q[0] != 0) begin
      errors++; $display("FAIL single_result got %p/%p expected [0]/[10]", served_q, ans_q);
    end
    // Req seen at edge 0; SEND_N, SEND_M, then 7 WAIT cycles (M sampled,
    // UNIT_LAT counts, Done sampled), pulse on the 10th cycle.
    checks++;
    if (first_lat != 10) begin
      errors++; $display("FAIL single_latency got %0d expected 10", first_lat);
    end
  endtask

  task automatic test_contention();
    pulse_reset();
    set_op(0, 8, 2); set_op(1, 6, 3); set_op(3, 5, 3);
    issue(4'b1011);
    serve(3, 400);
    checks++;
    if (served_q.size() != 3 || served_q[0] != 0 || served_q[1] != 1 || served_q[2] != 3) begin
      errors++; $display("FAIL contention_order got %p expected 0,1,3", served_q);
    end
    checks++;
    if (ans_q.size() != 3 || ans_q[0] != 28 || ans_q[1] != 20 || ans_q[2] != 10) begin
      errors++; $display("FAIL contention_answers got %p expected 28,20,10", ans_q);
    end
  endtask

  task automatic test_fairness();
    set_op(0, 4, 1); set_op(2, 7, 2);
    keep[0] = 1'b1;
    keep[2] = 1'b1;
    issue(4'b0101);
    serve(4, 600);
    checks++;
    if (served_q.size() != 4 || served_q[0] != 0 || served_q[1] != 2 ||
        served_q[2] != 0 || served_q[3] != 2) begin
      errors++; $display("FAIL fairness_order got %p expected 0,2,0,2", served_q);
    end
  endtask

  task automatic test_invalid();
    set_op(1, 2, 3);
    issue(4'b0010);
    serve(1, 50);
    checks++;
    if (served_q.size() != 1 || served_q[0] != 1 || ans_q[0] != 0 || err_q[0] != 1) begin
      errors++; $display("FAIL invalid_result got %p/%p/%p expected [1]/[0]/[1]", served_q, ans_q, err_q);
    end
  endtask

  task automatic test_reset_in_wait();
    int bad_pulse = 0;
    int bad_gnt = 0;
    int w;
    set_op(1, 7, 3); set_op(2, 9, 4);
    unit_dead = 1'b1;
    w = rr_model(4'b0110, mptr);
    issue(4'b0110);
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid != '0) bad_pulse++;
    end
    checks++;
    if (bad_pulse != 0) begin
      errors++; $display("FAIL wait_no_pulse got %0d pulses expected 0", bad_pulse);
    end
    checks++;
    if (gnt !== NREQ'(1 << w)) begin
      errors++; $display("FAIL wait_gnt got %b expected %b", gnt, NREQ'(1 << w));
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || rsp_valid !== '0 || u_start !== 1'b0 || u_n !== '0 ||
        rsp_err !== 1'b0 || rsp_answer !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got gnt=%b v=%b s=%b n=%0d e=%b a=%0d expected all 0",
               gnt, rsp_valid, u_start, u_n, rsp_err, rsp_answer);
    end
    rst = 1'b0;
    unit_dead = 1'b0;
    mptr = 0;
    serve(2, 400);
    checks++;
    if (served_q.size() != 2 || served_q[0] != 1 || served_q[1] != 2) begin
      errors++; $display("FAIL rearbitrate_order got %p expected 1,2", served_q);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] mask;
    int cnt;
    for (int r = 0; r < 20; r++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      cnt = 0;
      for (int i = 0; i < NREQ; i++) begin
        set_op(i, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
        if (mask[i]) cnt++;
      end
      issue(mask);
      serve(cnt, 100 * cnt);
    end
  endtask

`ifdef COMB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int lat = 0;
    int late = 0;
    pulse_reset();
    unit_dead = 1'b1;
    set_op(0, 5, 3);
    issue(4'b0001);
    while (rsp_valid == '0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    req = '0;
    pending = '0;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_answer !== '0) begin
      errors++; $display("FAIL timeout_rsp got %b/%b/%0d expected 0001/1/0", rsp_valid, rsp_err, rsp_answer);
    end
    checks++;
    if (lat != 13) begin
      errors++; $display("FAIL timeout_latency got %0d expected 13", lat);
    end
    late_done = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid != '0) late++;
    end
    late_done = 1'b0;
    checks++;
    if (late != 0) begin
      errors++; $display("FAIL late_done got %0d pulses expected 0", late);
    end
    unit_dead = 1'b0;
    pulse_reset();
  endtask
`endif

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      keep[i] = 1'b0;
      op_n[i] = 0;
      op_m[i] = 0;
    end
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_invalid();
    test_reset_in_wait();
    test_random();
`ifdef COMB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
